// File: rtl/regfile_dump_pkg.sv
// regfile_dump_pkg: register file geometry and dump engine state encodings
package regfile_dump_pkg;
  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;
  typedef enum logic [1:0] {DUMP_IDLE, DUMP_SEND, DUMP_DONE} dump_state_e;
endpackage

// File: rtl/regfile_dump.sv
// regfile_dump: sweeps a register address range and streams each word out over valid/ready
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first,
  input  logic [ADDR_W-1:0] last,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);
  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, last_q, last_d, out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              issued_q, issued_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic              ld, hs;
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    last_d     = last_q;
    issued_d   = issued_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    out_last_d = out_last_q;
    hs = out_valid_q && out_ready;
    ld = (state_q == DUMP_SEND) && (!out_valid_q || out_ready) && !issued_q;
    if (state_q == DUMP_IDLE && start) begin
      ptr_d    = first;
      last_d   = last;
      issued_d = 1'b0;
      state_d  = DUMP_SEND;
    end
    if (state_q == DUMP_DONE) state_d = DUMP_IDLE;
    // Pointer stops on the final register; ADDR_W-bit arithmetic gives the modulo wrap
    if (ld) begin
      out_data_d  = rd;
      out_addr_d  = ptr_q;
      out_last_d  = ptr_q == last_q;
      out_valid_d = 1'b1;
      if (ptr_q == last_q) issued_d = 1'b1;
      else ptr_d = ptr_q + 1'b1;
    end else if (hs) out_valid_d = 1'b0;
    if (state_q == DUMP_SEND && hs && out_last_q) state_d = DUMP_DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DUMP_IDLE;
      ptr_q       <= '0;
      last_q      <= '0;
      issued_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      last_q      <= last_d;
      issued_q    <= issued_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
    end
  end
  assign busy      = state_q == DUMP_SEND;
  assign done      = state_q == DUMP_DONE;
  assign ra        = ptr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
endmodule
